prio_enc_hexscan: RTL and testbench

Parametrised successor to the 8-to-3 priority encoder with seven-segment output. It encodes an N_IN-bit request vector to the index of its highest set bit and registers the result with valid, change and hold semantics. It drives a time-multiplexed bank of DIGITS hex seven-segment digits showing the code. It sits between board switches/requests and the NVBoard-style segment/anode pins.

---
 rtl/prio_enc_hexscan.sv | 126 ++++++++++++
 tb/tb_prio_enc_hexscan.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/prio_enc_hexscan.sv
// Priority encoder with registered code/valid/change flags and a scanned hex display.
// The display is decoded from registers only, so the segment pins do not glitch on x.
module prio_enc_hexscan #(
  parameter int N_IN     = 16,
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 1000,
  localparam int W       = $clog2(N_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_IN-1:0]   x,
  input  logic              en,
  input  logic              hold_mode,
  output logic [W-1:0]      code,
  output logic              valid,
  output logic              chg,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int XW = 4 * DIGITS;

  logic [W-1:0]    r_code;
  logic            r_valid;
  logic            r_chg;
  logic            r_latched;
  logic [CW-1:0]   r_scanCnt;
  logic [DW-1:0]   r_digit;

  logic [N_IN-1:0] w_req;
  logic            w_hasReq;
  logic [W-1:0]    w_idx;
  logic [W-1:0]    w_nextCode;
  logic            w_scanWrap;
  logic [XW-1:0]   w_codeExt;
  logic [3:0]      w_nibble;
  logic            w_blank;

  function automatic logic [6:0] hexFont(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Ascending scan lets the highest set bit win.
  always_comb begin
    w_req    = en ? x : '0;
    w_hasReq = (w_req != '0);
    w_idx    = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (w_req[i]) w_idx = W'(i);
    end
    if (w_hasReq)       w_nextCode = w_idx;
    else if (hold_mode) w_nextCode = r_code;
    else                w_nextCode = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_code    <= '0;
      r_valid   <= 1'b0;
      r_chg     <= 1'b0;
      r_latched <= 1'b0;
    end else begin
      r_code  <= w_nextCode;
      r_chg   <= (w_nextCode != r_code);
      r_valid <= w_hasReq;
      if (w_hasReq)       r_latched <= 1'b1;
      else if (!hold_mode) r_latched <= 1'b0;
    end
  end

  assign w_scanWrap = (r_scanCnt == CW'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scanCnt <= '0;
      r_digit   <= '0;
    end else begin
      r_scanCnt <= w_scanWrap ? '0 : r_scanCnt + 1'b1;
      if (w_scanWrap) begin
        r_digit <= (r_digit == DW'(DIGITS - 1)) ? '0 : r_digit + 1'b1;
      end
    end
  end

  // Display stays lit while a held code is being shown with no live request.
  always_comb begin
    w_codeExt          = '0;
    w_codeExt[W-1:0]   = r_code;
    w_nibble           = '0;
    an                 = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_digit == DW'(k)) begin
        an[k]    = 1'b0;
        w_nibble = w_codeExt[4*k +: 4];
      end
    end
    w_blank = !r_valid && !(hold_mode && r_latched);
    seg     = w_blank ? 7'b1111111 : hexFont(w_nibble);
  end

  assign code  = r_code;
  assign valid = r_valid;
  assign chg   = r_chg;

endmodule

// File: tb/tb_prio_enc_hexscan.sv
// Directed bench for prio_enc_hexscan: a 16-input/2-digit instance and an 8-input/3-digit
// instance with single-cycle scanning, each task checking its own scenario inline.
module tb_prio_enc_hexscan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] x16;
  logic        en16, hold16;
  logic [3:0]  code16;
  logic        valid16, chg16;
  logic [1:0]  an16;
  logic [6:0]  seg16;
  logic [7:0]  x8;
  logic        en8, hold8;
  logic [2:0]  code8;
  logic        valid8, chg8;
  logic [2:0]  an8;
  logic [6:0]  seg8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  prio_enc_hexscan #(.N_IN(16), .DIGITS(2), .SCAN_DIV(4)) dut16 (
    .clk(clk), .rst(rst), .x(x16), .en(en16), .hold_mode(hold16),
    .code(code16), .valid(valid16), .chg(chg16), .an(an16), .seg(seg16)
  );

  prio_enc_hexscan #(.N_IN(8), .DIGITS(3), .SCAN_DIV(1)) dut8 (
    .clk(clk), .rst(rst), .x(x8), .en(en8), .hold_mode(hold8),
    .code(code8), .valid(valid8), .chg(chg8), .an(an8), .seg(seg8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    x16 = 16'hFFFF; en16 = 1'b1; hold16 = 1'b1;
    doReset();
    x16 = '0; en16 = 1'b0; hold16 = 1'b0;
    total++; if (code16 !== 4'd0) begin bad++; $display("[TB] FAIL reset_code got=%0d want=0", code16); end
    total++; if (valid16 !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", valid16); end
    total++; if (chg16 !== 1'b0) begin bad++; $display("[TB] FAIL reset_chg got=%b want=0", chg16); end
    total++; if (an16 !== 2'b10) begin bad++; $display("[TB] FAIL reset_an got=%b want=10", an16); end
    total++; if (seg16 !== 7'b1111111) begin bad++; $display("[TB] FAIL reset_seg got=%b want=1111111", seg16); end
  endtask

  task automatic test_basic();
    doReset();
    x16 = 16'h0009; en16 = 1'b1; hold16 = 1'b0;
    tick();
    total++; if (code16 !== 4'd3) begin bad++; $display("[TB] FAIL basic_code got=%0d want=3", code16); end
    total++; if (valid16 !== 1'b1) begin bad++; $display("[TB] FAIL basic_valid got=%b want=1", valid16); end
    total++; if (chg16 !== 1'b1) begin bad++; $display("[TB] FAIL basic_chg got=%b want=1", chg16); end
    total++; if (seg16 !== 7'b0110000) begin bad++; $display("[TB] FAIL basic_seg0 got=%b want=0110000", seg16); end
    tick();
    total++; if (chg16 !== 1'b0) begin bad++; $display("[TB] FAIL basic_chg_drop got=%b want=0", chg16); end
    tick(); tick();
    total++; if (an16 !== 2'b01) begin bad++; $display("[TB] FAIL basic_an1 got=%b want=01", an16); end
    total++; if (seg16 !== 7'b1000000) begin bad++; $display("[TB] FAIL basic_seg1 got=%b want=1000000", seg16); end
    repeat (4) tick();
    total++; if (an16 !== 2'b10) begin bad++; $display("[TB] FAIL basic_an_wrap got=%b want=10", an16); end
    total++; if (seg16 !== 7'b0110000) begin bad++; $display("[TB] FAIL basic_seg_wrap got=%b want=0110000", seg16); end
  endtask

  task automatic test_high_bit();
    int pulses;
    doReset();
    x16 = 16'h8001; en16 = 1'b1; hold16 = 1'b0;
    pulses = 0;
    tick();
    total++; if (code16 !== 4'd15) begin bad++; $display("[TB] FAIL high_code got=%0d want=15", code16); end
    total++; if (seg16 !== 7'b0001110) begin bad++; $display("[TB] FAIL high_seg got=%b want=0001110", seg16); end
    if (chg16 === 1'b1) pulses++;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (chg16 === 1'b1) pulses++;
    end
    total++; if (pulses !== 1) begin bad++; $display("[TB] FAIL high_pulses got=%0d want=1", pulses); end
    x16 = 16'h0001;
    tick();
    total++; if (code16 !== 4'd0) begin bad++; $display("[TB] FAIL bit0_code got=%0d want=0", code16); end
    total++; if (valid16 !== 1'b1) begin bad++; $display("[TB] FAIL bit0_valid got=%b want=1", valid16); end
    total++; if (chg16 !== 1'b1) begin bad++; $display("[TB] FAIL bit0_chg got=%b want=1", chg16); end
    total++; if (seg16 !== 7'b1000000) begin bad++; $display("[TB] FAIL bit0_seg got=%b want=1000000", seg16); end
  endtask

  task automatic test_clear_and_hold();
    doReset();
    x16 = 16'h8000; en16 = 1'b1; hold16 = 1'b0;
    tick();
    en16 = 1'b0;
    tick();
    total++; if (code16 !== 4'd0) begin bad++; $display("[TB] FAIL clear_code got=%0d want=0", code16); end
    total++; if (valid16 !== 1'b0) begin bad++; $display("[TB] FAIL clear_valid got=%b want=0", valid16); end
    total++; if (chg16 !== 1'b1) begin bad++; $display("[TB] FAIL clear_chg got=%b want=1", chg16); end
    total++; if (seg16 !== 7'b1111111) begin bad++; $display("[TB] FAIL clear_seg0 got=%b want=1111111", seg16); end
    tick(); tick();
    total++; if (an16 !== 2'b01 || seg16 !== 7'b1111111) begin bad++; $display("[TB] FAIL clear_seg1 got=%b/%b want=01/1111111", an16, seg16); end

    doReset();
    x16 = 16'h8000; en16 = 1'b1; hold16 = 1'b1;
    tick();
    en16 = 1'b0;
    tick();
    total++; if (code16 !== 4'd15) begin bad++; $display("[TB] FAIL hold_code got=%0d want=15", code16); end
    total++; if (valid16 !== 1'b0) begin bad++; $display("[TB] FAIL hold_valid got=%b want=0", valid16); end
    total++; if (chg16 !== 1'b0) begin bad++; $display("[TB] FAIL hold_chg got=%b want=0", chg16); end
    total++; if (seg16 !== 7'b0001110) begin bad++; $display("[TB] FAIL hold_seg got=%b want=0001110", seg16); end
    hold16 = 1'b0;
    tick();
    total++; if (code16 !== 4'd0) begin bad++; $display("[TB] FAIL unhold_code got=%0d want=0", code16); end
    total++; if (chg16 !== 1'b1) begin bad++; $display("[TB] FAIL unhold_chg got=%b want=1", chg16); end
    total++; if (seg16 !== 7'b1111111) begin bad++; $display("[TB] FAIL unhold_seg got=%b want=1111111", seg16); end
  endtask

  task automatic test_reset_mid();
    doReset();
    x16 = 16'h0080; en16 = 1'b1; hold16 = 1'b1;
    tick();
    en16 = 1'b0;
    repeat (5) tick();
    total++; if (an16 !== 2'b01 || code16 !== 4'd7) begin bad++; $display("[TB] FAIL mid_pre got=%b/%0d want=01/7", an16, code16); end
    total++; if (seg16 !== 7'b1000000) begin bad++; $display("[TB] FAIL mid_pre_seg got=%b want=1000000", seg16); end
    doReset();
    total++; if (code16 !== 4'd0) begin bad++; $display("[TB] FAIL mid_code got=%0d want=0", code16); end
    total++; if (chg16 !== 1'b0) begin bad++; $display("[TB] FAIL mid_chg got=%b want=0", chg16); end
    total++; if (an16 !== 2'b10) begin bad++; $display("[TB] FAIL mid_an got=%b want=10", an16); end
    total++; if (seg16 !== 7'b1111111) begin bad++; $display("[TB] FAIL mid_seg got=%b want=1111111", seg16); end
    repeat (3) tick();
    total++; if (an16 !== 2'b10) begin bad++; $display("[TB] FAIL mid_cnt3 got=%b want=10", an16); end
    tick();
    total++; if (an16 !== 2'b01) begin bad++; $display("[TB] FAIL mid_cnt4 got=%b want=01", an16); end
    hold16 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] vecs [5];
    logic [3:0]  expCode [5];
    logic        expChg [5];
    vecs[0] = 16'h0010; expCode[0] = 4'd4;  expChg[0] = 1'b1;
    vecs[1] = 16'h0030; expCode[1] = 4'd5;  expChg[1] = 1'b1;
    vecs[2] = 16'h0020; expCode[2] = 4'd5;  expChg[2] = 1'b0;
    vecs[3] = 16'h0400; expCode[3] = 4'd10; expChg[3] = 1'b1;
    vecs[4] = 16'hFFFF; expCode[4] = 4'd15; expChg[4] = 1'b1;
    doReset();
    en16 = 1'b1; hold16 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      x16 = vecs[i];
      tick();
      total++; if (code16 !== expCode[i]) begin bad++; $display("[TB] FAIL b2b_code[%0d] got=%0d want=%0d", i, code16, expCode[i]); end
      total++; if (chg16 !== expChg[i]) begin bad++; $display("[TB] FAIL b2b_chg[%0d] got=%b want=%b", i, chg16, expChg[i]); end
    end
    total++; if (seg16 !== 7'b1000000) begin bad++; $display("[TB] FAIL b2b_seg got=%b want=1000000", seg16); end
    x16 = '0; en16 = 1'b0;
  endtask

  task automatic test_fast_scan();
    logic [2:0] expAn [4];
    logic [6:0] expSeg [4];
    expAn[0] = 3'b110; expSeg[0] = 7'b1111000;
    expAn[1] = 3'b101; expSeg[1] = 7'b1000000;
    expAn[2] = 3'b011; expSeg[2] = 7'b1000000;
    expAn[3] = 3'b110; expSeg[3] = 7'b1111000;
    x8 = 8'h80; en8 = 1'b1; hold8 = 1'b0;
    doReset();
    tick();
    total++; if (code8 !== 3'd7 || valid8 !== 1'b1) begin bad++; $display("[TB] FAIL fast_code got=%0d/%b want=7/1", code8, valid8); end
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (an8 !== expAn[i]) begin bad++; $display("[TB] FAIL fast_an[%0d] got=%b want=%b", i, an8, expAn[i]); end
      total++; if (seg8 !== expSeg[i]) begin bad++; $display("[TB] FAIL fast_seg[%0d] got=%b want=%b", i, seg8, expSeg[i]); end
    end
    total++; if (chg8 !== 1'b0) begin bad++; $display("[TB] FAIL fast_chg got=%b want=0", chg8); end
  endtask

  initial begin
    rst = 1'b0;
    x16 = '0; en16 = 1'b0; hold16 = 1'b0;
    x8 = '0; en8 = 1'b0; hold8 = 1'b0;
    #2;
    test_reset();
    test_basic();
    test_high_bit();
    test_clear_and_hold();
    test_reset_mid();
    test_back_to_back();
    test_fast_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
